rs485_bus_arb: RTL and testbench

RS485_BUS_ARB -- requirements
Module: rs485_bus_arb

---
 rtl/rs485_bus_arb.sv | 135 +++++++++++++
 tb/tb_rs485_bus_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs485_bus_arb.sv
// Two-requester RS-485 half-duplex bus arbiter with driver-enable guard timing.
// Define RS485_ARB_RR_EN for round-robin arbitration; the default is fixed priority to requester 0.
module rs485_bus_arb #(
   parameter int GUARD_CYC = 16,
   parameter int IDLE_TO   = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   input  logic [1:0]  byte_valid,
   input  logic [15:0] byte_data,
   output logic [1:0]  byte_ready,
   input  logic        rx_active,
   input  logic        uart_tx_busy,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_en,
   output logic        rs485_de
);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT_TX, HOLD} state_t;

   localparam logic [7:0]  GUARD_INIT = 8'(GUARD_CYC);
   localparam logic [15:0] IDLE_LAST  = 16'(IDLE_TO - 1);

   state_t      state, state_nx;
   logic [7:0]  guard, guard_nx;
   logic [15:0] idle_cnt, idle_nx;
   logic        sel, sel_nx;
   logic        wt_first, wt_first_nx;
   logic        win;
`ifdef RS485_ARB_RR_EN
   logic        last, last_nx;
`endif

   function automatic logic [7:0] dec_sat(input logic [7:0] v);
      return (v == 8'd0) ? 8'd0 : v - 8'd1;
   endfunction

   function automatic logic [15:0] inc_sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      win = ~req[0];
`ifdef RS485_ARB_RR_EN
      if (&req) win = ~last;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         guard    <= 8'd0;
         idle_cnt <= 16'd0;
         sel      <= 1'b0;
         wt_first <= 1'b0;
`ifdef RS485_ARB_RR_EN
         last     <= 1'b1;
`endif
      end else begin
         state    <= state_nx;
         guard    <= guard_nx;
         idle_cnt <= idle_nx;
         sel      <= sel_nx;
         wt_first <= wt_first_nx;
`ifdef RS485_ARB_RR_EN
         last     <= last_nx;
`endif
      end
   end

   always_comb begin
      state_nx     = state;
      guard_nx     = guard;
      idle_nx      = idle_cnt;
      sel_nx       = sel;
      wt_first_nx  = 1'b0;
      byte_ready   = 2'b00;
      uart_tx_en   = 1'b0;
      uart_tx_data = 8'd0;
`ifdef RS485_ARB_RR_EN
      last_nx      = last;
`endif
      case (state)
         IDLE: begin
            if ((|req) && !rx_active && !uart_tx_busy) begin
               sel_nx   = win;
               guard_nx = GUARD_INIT;
               idle_nx  = 16'd0;
               state_nx = SETUP;
`ifdef RS485_ARB_RR_EN
               last_nx  = win;
`endif
            end
         end
         SETUP: begin
            guard_nx = dec_sat(guard);
            if (guard_nx == 8'd0) state_nx = XFER;
         end
         XFER: begin
            // A dropped request ends the frame even if a byte is still offered.
            if (!req[sel]) begin
               guard_nx = GUARD_INIT;
               state_nx = HOLD;
            end else if (byte_valid[sel]) begin
               byte_ready[sel] = 1'b1;
               uart_tx_en      = 1'b1;
               uart_tx_data    = sel ? byte_data[15:8] : byte_data[7:0];
               idle_nx         = 16'd0;
               wt_first_nx     = 1'b1;
               state_nx        = WAIT_TX;
            end else if (idle_cnt >= IDLE_LAST) begin
               guard_nx = GUARD_INIT;
               state_nx = HOLD;
            end else begin
               idle_nx = inc_sat(idle_cnt);
            end
         end
         WAIT_TX: begin
            // The UART raises busy one cycle after the start pulse, so skip that cycle.
            if (!wt_first && !uart_tx_busy) state_nx = XFER;
         end
         HOLD: begin
            guard_nx = dec_sat(guard);
            if (guard_nx == 8'd0) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign rs485_de = (state != IDLE);
   assign gnt      = (state == IDLE) ? 2'b00 : (sel ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_rs485_bus_arb.sv
// Randomized self-checking bench for rs485_bus_arb; expectations come from a frame-level model
// of the arbitration and guard-timing rules.
module tb_rs485_bus_arb;

   localparam int G   = 4;
   localparam int ITO = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [1:0]  byte_valid;
   logic [15:0] byte_data;
   logic [1:0]  byte_ready;
   logic        rx_active;
   logic        uart_tx_busy;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_en;
   logic        rs485_de;

   int n_cmp = 0;
   int n_mis = 0;
   int last_w = 1;
   logic [7:0] frame_bytes[$];

   rs485_bus_arb #(.GUARD_CYC(G), .IDLE_TO(ITO)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .rx_active(rx_active), .uart_tx_busy(uart_tx_busy),
      .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en), .rs485_de(rs485_de)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // Arbitration rule: a lone requester wins; on a tie requester 0 wins, or under round-robin
   // whichever requester was not granted last.
   function automatic int winner(input logic [1:0] r);
      if (r == 2'b01) return 0;
      if (r == 2'b10) return 1;
`ifdef RS485_ARB_RR_EN
      return (last_w == 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic run_frame(input logic [1:0] reqs, input int rx_cyc, input bit inject);
      int w, o, lat, de_pre, tail, idx, delay, busy_left;
      bit first, prev_en, done;
      logic [7:0] q[$];
      q = frame_bytes;
      w = winner(reqs);
      o = 1 - w;
      last_w = w;
      req = reqs;
      rx_active = (rx_cyc > 0);
      uart_tx_busy = 1'b0;
      byte_valid = 2'b00;
      if (inject) begin
         byte_valid[o] = 1'b1;
         byte_data[o*8 +: 8] = 8'($urandom);
      end
      byte_valid[w] = 1'b1;
      byte_data[w*8 +: 8] = q[0];
      lat = 0;
      done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         #3;
         if (gnt != 2'b00) begin
            done = 1'b1;
            break;
         end
         check_eq("idle_de", 32'(rs485_de), 32'd0);
         @(posedge clk); #1;
         lat++;
         if (lat >= rx_cyc) rx_active = 1'b0;
      end
      check_eq("grant_seen", 32'(done), 32'd1);
      check_eq("gnt_lat", lat, rx_cyc + 1);
      check_eq("gnt_win", 32'(gnt), (w != 0) ? 32'd2 : 32'd1);
      check_eq("de_at_gnt", 32'(rs485_de), 32'd1);

      de_pre = 1; idx = 0; delay = 0; busy_left = 0;
      first = 1'b1; prev_en = 1'b0; done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (idx == q.size() && busy_left == 0) begin
            done = 1'b1;
            break;
         end
         uart_tx_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
         if (delay > 0) begin
            delay--;
            byte_valid[w] = 1'b0;
         end else if (idx < q.size()) begin
            byte_valid[w] = 1'b1;
            byte_data[w*8 +: 8] = q[idx];
         end else begin
            byte_valid[w] = 1'b0;
         end
         if (inject) byte_data[o*8 +: 8] = 8'($urandom);
         #3;
         check_eq("gnt_hold", 32'(gnt), (w != 0) ? 32'd2 : 32'd1);
         check_eq("rdy_other", 32'(byte_ready[o]), 32'd0);
         check_eq("en_vs_rdy", 32'(uart_tx_en), 32'(byte_ready[w]));
         if (uart_tx_en) begin
            if (first) check_eq("de_setup", de_pre, G);
            first = 1'b0;
            check_eq("en_pulse", 32'(prev_en), 32'd0);
            if (idx < q.size()) begin
               check_eq("tx_data", 32'(uart_tx_data), 32'(q[idx]));
               idx++;
            end else begin
               check_eq("extra_byte", 32'(uart_tx_en), 32'd0);
            end
            busy_left = $urandom_range(1, 4);
            delay = $urandom_range(0, 2);
         end else if (first && rs485_de) begin
            de_pre++;
         end
         prev_en = uart_tx_en;
      end
      check_eq("frame_done", 32'(done), 32'd1);

      req = 2'b00;
      byte_valid = 2'b00;
      uart_tx_busy = 1'b0;
      tail = 0;
      for (int c = 0; c < 100; c++) begin
         #3;
         if (!rs485_de) break;
         tail++;
         @(posedge clk); #1;
      end
      check_eq("de_tail", tail, G + 2);
      check_eq("gnt_off", 32'(gnt), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_timeout(input logic [1:0] reqs);
      int w, lat, cnt;
      w = winner(reqs);
      last_w = w;
      req = reqs;
      byte_valid = 2'b00;
      lat = 0;
      for (int c = 0; c < 50; c++) begin
         #3;
         if (gnt != 2'b00) break;
         @(posedge clk); #1;
         lat++;
      end
      check_eq("to_gnt_lat", lat, 1);
      check_eq("to_gnt_win", 32'(gnt), (w != 0) ? 32'd2 : 32'd1);
      cnt = 0;
      for (int c = 0; c < 200; c++) begin
         if (!rs485_de) break;
         cnt++;
         @(posedge clk); #4;
      end
      req = 2'b00;
      check_eq("to_de_len", cnt, 2 * G + ITO);
      check_eq("to_gnt_off", 32'(gnt), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset_n = 1'b0;
      req = 2'b00;
      byte_valid = 2'b00;
      byte_data = 16'h0000;
      rx_active = 1'b0;
      uart_tx_busy = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_de", 32'(rs485_de), 32'd0);
      check_eq("rst_en", 32'(uart_tx_en), 32'd0);
      check_eq("rst_rdy", 32'(byte_ready), 32'd0);
      check_eq("rst_data", 32'(uart_tx_data), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      last_w = 1;
      @(posedge clk); #1;

      // Two-byte frame from requester 0.
      frame_bytes = '{8'h53, 8'h0D};
      run_frame(2'b01, 0, 1'b0);

      // Reset pulse while waiting on the UART.
      req = 2'b01;
      byte_valid = 2'b01;
      byte_data = 16'h00A5;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #3;
         if (uart_tx_en) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check_eq("rst_tx_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
      uart_tx_busy = 1'b1;
      byte_valid = 2'b00;
      #1 reset_n = 1'b0;
      #1;
      check_eq("async_de", 32'(rs485_de), 32'd0);
      check_eq("async_gnt", 32'(gnt), 32'd0);
      check_eq("async_en", 32'(uart_tx_en), 32'd0);
      req = 2'b00;
      uart_tx_busy = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      last_w = 1;
      #3;
      check_eq("post_rst_de", 32'(rs485_de), 32'd0);
      check_eq("post_rst_gnt", 32'(gnt), 32'd0);
      @(posedge clk); #1;

      // Simultaneous requests twice.
      frame_bytes = '{8'h11};
      run_frame(2'b11, 0, 1'b0);
      frame_bytes = '{8'h22, 8'h33};
      run_frame(2'b11, 0, 1'b0);

      // Receiver busy holds off the grant.
      frame_bytes = '{8'h7E};
      run_frame(2'b10, 50, 1'b0);

      run_timeout(2'b01);

      // Stray byte_valid from the non-granted requester.
      frame_bytes = '{8'hC3, 8'h3C, 8'h99};
      run_frame(2'b10, 0, 1'b1);

      for (int f = 0; f < 12; f++) begin
         int nb;
         frame_bytes.delete();
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) frame_bytes.push_back(8'($urandom));
         run_frame(2'($urandom_range(1, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
